// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_pkg
// Brief   : Shared Wishbone bus types and constants for the CPU master port.
// Revision: 1.0
// ============================================================================
package wb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } wb_state_e;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;

    // RAM slave decodes adr[31:18] against this value.
    localparam logic [13:0] WB_RAM_REGION = 14'h0000;
    localparam logic [31:0] WB_ERR_RDATA  = 32'h0000_0000;

    function automatic logic wb_is_ram(input logic [WB_ADDR_W-1:0] adr);
        return adr[31:18] == WB_RAM_REGION;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module  : wb_timeout_ctr
// Brief   : Saturating bus-cycle counter flagging the last permitted cycle.
// Revision: 1.0
// ============================================================================
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (clr_i) begin
                    cnt_q <= '0;
                end else if (en_i && (cnt_q != C_MAX)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            // Flag the final allowed cycle so termination lands exactly
            // TIMEOUT_CYCLES cycles after the bus cycle opens.
            assign expired_o = en_i && (cnt_q == C_LAST);
        end else begin : g_no_timeout
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_master_port.sv
`default_nettype none
// ============================================================================
// Module  : wb_master_port
// Brief   : CPU-side Wishbone classic initiator, one single-beat cycle at a time.
// Revision: 1.0
// ============================================================================
module wb_master_port
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = WB_ADDR_W,
    parameter int DATA_W         = WB_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_sel,
    output logic                cpu_busy,
    output logic                cpu_done,
    output logic                cpu_err,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    localparam int SEL_W = DATA_W / 8;

    wb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0]  dat_q, dat_d;
    logic               we_q, we_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ctr_clr, ctr_en, ctr_expired;

    // Byte lanes come from cpu_sel, so the low address bits carry no information.
    logic w_unused_addr_lo;
    assign w_unused_addr_lo = ^cpu_addr[1:0];

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (ctr_clr),
        .en_i      (ctr_en),
        .expired_o (ctr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    adr_d   = {cpu_addr[ADDR_W-1:2], 2'b00};
                    dat_d   = cpu_wdata;
                    we_d    = cpu_we;
                    sel_d   = cpu_sel;
                    ctr_clr = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                ctr_en = 1'b1;
                // Error outranks ack, ack outranks the timeout.
                if (wb_err_i || (!wb_ack_i && ctr_expired)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = DATA_W'(WB_ERR_RDATA);
                    end
                end else if (wb_ack_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = wb_dat_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_busy  = (state_q == ACTIVE);
    assign wb_cyc_o  = (state_q == ACTIVE);
    assign wb_stb_o  = (state_q == ACTIVE);
    assign cpu_done  = done_q;
    assign cpu_err   = err_q;
    assign cpu_rdata = rdata_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_master_port
// Brief   : Self-checking bench for wb_master_port with TIMEOUT_CYCLES = 8.
// Revision: 1.0
// ============================================================================
module tb_wb_master_port;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_sel;
    logic        cpu_busy, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o, wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i;

    int n_checks = 0;
    int n_pass   = 0;

    wb_master_port #(
        .TIMEOUT_CYCLES (T),
        .ADDR_W         (32),
        .DATA_W         (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_sel   (cpu_sel),
        .cpu_busy  (cpu_busy),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    endtask

    // resp_at: active-cycle index (0 = first cyc cycle) at which the slave responds;
    // kind: 0 ack, 1 err, 2 ack+err; resp_at < 0 means the slave never answers.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          resp_at;
        int          kind;
        logic [31:0] sdata;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    // Presents one request at a negedge and plays the slave until cpu_done.
    // lat counts cycles from the first wb_cyc_o cycle to the cpu_done cycle.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input int resp_at, input int kind,
                          input logic [31:0] sdata, input bit noise, input string tag,
                          output int lat, output logic err, output logic [31:0] rd,
                          output int busy_n);
        logic [31:0] exp_adr;
        bit          stable;
        exp_adr = addr & 32'hFFFF_FFFC;
        stable  = 1'b1;
        lat     = -1;
        err     = 1'b0;
        rd      = 32'h0;
        busy_n  = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_sel = sel;
        @(negedge clk);
        check({tag, "_cyc_open"}, {29'b0, wb_cyc_o, wb_stb_o, cpu_busy}, 32'h7);
        check({tag, "_wb_adr"}, wb_adr_o, exp_adr);
        check({tag, "_wb_dat"}, wb_dat_o, wdata);
        check({tag, "_wb_we_sel"}, {27'b0, wb_we_o, wb_sel_o}, {27'b0, we, sel});
        for (int k = 0; k < 40; k++) begin
            if (cpu_done) begin
                lat = k; err = cpu_err; rd = cpu_rdata;
                cpu_req = 1'b0;
                stable = stable && !wb_cyc_o && !cpu_busy;
                break;
            end
            busy_n += int'(cpu_busy);
            stable = stable && wb_cyc_o && wb_stb_o && (wb_adr_o == exp_adr) &&
                     (wb_we_o == we) && (wb_sel_o == sel) && (wb_dat_o == wdata);
            if (noise) begin
                cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = $urandom;
                cpu_wdata = $urandom; cpu_sel = 4'($urandom);
            end else begin
                cpu_req = 1'b0;
            end
            wb_ack_i = (k == resp_at) && (kind != 1);
            wb_err_i = (k == resp_at) && (kind != 0);
            wb_dat_i = (k == resp_at) ? sdata : $urandom;
            @(negedge clk);
            wb_ack_i = 1'b0; wb_err_i = 1'b0;
        end
        cpu_req = 1'b0;
        check({tag, "_held_stable"}, {31'b0, stable}, 32'h1);
    endtask

    task automatic run_checked(input vec_t v, input bit noise, input string tag);
        int lat, busy_n;
        logic err;
        logic [31:0] rd;
        do_txn(v.we, v.addr, v.wdata, v.sel, v.resp_at, v.kind, v.sdata, noise, tag,
               lat, err, rd, busy_n);
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_busy_cycles"}, busy_n, v.exp_lat);
        check({tag, "_err"}, {31'b0, err}, {31'b0, v.exp_err});
        check({tag, "_rdata"}, rd, v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] model_rd;
        vec_t        rv;
        bit          responded;

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_sel = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ctrl", {26'b0, wb_cyc_o, wb_stb_o, cpu_busy, cpu_done, cpu_err, wb_we_o}, 32'h0);
        check("rst_adr", wb_adr_o, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_sel", {28'b0, wb_sel_o}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);

        // Spurious slave response while idle must not disturb anything.
        @(negedge clk);
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        check("idle_ack_ignored", {28'b0, wb_cyc_o, cpu_busy, cpu_done, cpu_err}, 32'h0);
        check("idle_ack_rdata", cpu_rdata, 32'h0);

        vecs[0] = '{1'b1, 32'h0000_0104, 32'hA5A5_1234, 4'hF, 0, 0, 32'h0,         1, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_2000, 32'h0,         4'hF, 3, 0, 32'hCAFE_F00D, 4, 1'b0, 32'hCAFE_F00D};
        vecs[2] = '{1'b0, 32'h0000_3008, 32'h0,         4'h3, 1, 2, 32'h7777_7777, 2, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_4003, 32'h0,         4'hF, -1, 0, 32'h0,        T, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 0, 0, 32'h1234_5678, 1, 1'b0, 32'h1234_5678};
        vecs[5] = '{1'b1, 32'h0000_0010, 32'h9999_0000, 4'hC, 2, 1, 32'h0,         3, 1'b1, 32'h1234_5678};
        vecs[6] = '{1'b0, 32'h8000_0044, 32'h0,         4'hF, T-1, 0, 32'hDEAD_BEEF, T, 1'b0, 32'hDEAD_BEEF};
        vecs[7] = '{1'b1, 32'h8000_0048, 32'h0BAD_0BAD, 4'h1, T-1, 0, 32'h0,       T, 1'b0, 32'hDEAD_BEEF};
        for (int i = 0; i < 8; i++) begin
            run_checked(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Back-to-back with cpu_req held; inputs changed while busy are ignored.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50; cpu_sel = 4'hF; cpu_wdata = 32'h0;
        @(negedge clk);
        check("b2b_first_adr", wb_adr_o, 32'h50);
        cpu_addr = 32'h62; cpu_we = 1'b1; cpu_wdata = 32'h55AA_55AA;
        @(negedge clk);
        check("b2b_busy_req_ignored", {wb_adr_o[30:0], wb_we_o}, {31'h50, 1'b0});
        wb_ack_i = 1'b1; wb_dat_i = 32'h1111_2222;
        @(negedge clk);
        wb_ack_i = 1'b0;
        check("b2b_first_done", {29'b0, cpu_done, wb_cyc_o, cpu_err}, 32'h4);
        check("b2b_first_rdata", cpu_rdata, 32'h1111_2222);
        @(negedge clk);
        check("b2b_second_open", {30'b0, wb_cyc_o, wb_we_o}, 32'h3);
        check("b2b_second_adr", wb_adr_o, 32'h60);
        check("b2b_second_dat", wb_dat_o, 32'h55AA_55AA);
        cpu_req = 1'b0; wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        check("b2b_second_done", {30'b0, cpu_done, cpu_err}, 32'h2);
        check("b2b_store_keeps_rdata", cpu_rdata, 32'h1111_2222);
        @(negedge clk);
        check("b2b_done_one_cycle", {30'b0, cpu_done, wb_cyc_o}, 32'h0);

        // Asynchronous reset in the middle of a bus cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; cpu_sel = 4'hF;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_async", {27'b0, wb_cyc_o, wb_stb_o, cpu_busy, cpu_done, cpu_err}, 32'h0);
        @(negedge clk);
        check("rst_mid_no_done", {31'b0, cpu_done}, 32'h0);
        rst = 1'b0;
        rv = '{1'b0, 32'h0000_0084, 32'h0, 4'hF, 1, 0, 32'h0BAD_F00D, 2, 1'b0, 32'h0BAD_F00D};
        run_checked(rv, 1'b0, "post_rst");
        model_rd = 32'h0BAD_F00D;

        // Random traffic against a response-rule model.
        for (int i = 0; i < 24; i++) begin
            rv.we      = 1'($urandom);
            rv.addr    = $urandom;
            rv.wdata   = $urandom;
            rv.sel     = 4'($urandom);
            rv.resp_at = int'($urandom_range(0, 10)) - 1;
            rv.kind    = int'($urandom_range(0, 2));
            rv.sdata   = $urandom;
            responded  = (rv.resp_at >= 0) && (rv.resp_at < T);
            rv.exp_lat = responded ? rv.resp_at + 1 : T;
            rv.exp_err = !responded || (rv.kind != 0);
            if (!rv.we) model_rd = rv.exp_err ? 32'h0 : rv.sdata;
            rv.exp_rdata = model_rd;
            run_checked(rv, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
